fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Multi-cycle sequencer for the 8-bit floating-point add/subtract unit. It captures two operands and an op code under a start/done handshake, then steps the exponent and mantissa datapath through four phases: compare, one-bit-per-cycle alignment, add/subtract, and one-bit-per-cycle normalization. It returns a packed result with overflow and underflow flags. It sits between the requesting logic and the FP arithmetic and replaces the combinational single-shot path.

## Interface
- Number format (fixed, no parameters): bit 7 = sign, bits 6:4 = exponent e (unsigned), bits 3:0 = fraction f.
  - Value = 1.f × 2^e.
  - An exponent field of 0 means zero; the fraction is ignored.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = A+B, 1 = A−B; captured with start.
- a  in  8  operand A; captured with start.
- b  in  8  operand B; captured with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; y/ovf/unf are valid from this cycle on.
- y  out  8  registered result; held until the next accepted start.
- ovf  out  1  exponent overflow on the last operation.
- unf  out  1  exponent underflow on the last operation.

## Operation
- States: IDLE, ALIGN, ADD, NORM, DONE.
- Reset values: state = IDLE; y = 8'h00; ovf = unf = done = busy = 0. Reset wins over every other event, including mid-operation; an in-flight operation is discarded.

IDLE, on start = 1:
- Capture the operands. Effective B sign: sb' = b[7] ^ op.
- If a.e == 0: y = {sb', b[6:0]} → DONE.
- Else if b.e == 0: y = a → DONE.
- Otherwise, with mantissas mA = {1, a.f} and mB = {1, b.f} (5 bits):
  - L = the larger magnitude, compared on {e, f}; on a tie, L = A. S = the other operand.
  - Result sign = sign of L (using sb' for B).
  - eff_sub = a[7] ^ sb'.
  - Exponent register = L.e. Align counter = L.e − S.e (0..7).
  - Next state: ALIGN if the count > 0, else ADD.

ALIGN:
- Each cycle: mS >>= 1 (zero fill; shifted-out bits are discarded, no rounding) and the counter decrements.
- Go to ADD in the cycle the counter reaches 0.

ADD (one cycle): 6-bit result register R = mL + mS (add) or mL − mS (eff_sub; never negative).
- R == 0: y = 8'h00 → DONE.
- Else → NORM.

NORM (one cycle per step):
- If R[5] = 1:
  - If exp == 7: ovf = 1, y = {sign, 7'h7F}.
  - Else R >>= 1 and exp += 1.
  - Either way → DONE.
- Else if R[4] = 1: → DONE.
- Else (R[4] = 0):
  - If exp == 1: unf = 1, y = 8'h00 → DONE.
  - Else R <<= 1, exp −= 1; stay in NORM.

DONE:
- Unless set by a special case above, y = {sign, exp, R[3:0]}.
- done = 1 for this cycle only → IDLE.
- ovf/unf are cleared on accepting a new start and set only as described above.

start is ignored while busy, and also in the DONE cycle.

## Timing
- The accept edge is the first rising edge with IDLE && start.
- done rises N cycles after the accept edge:
  - N = 1 for a zero operand.
  - N = 2 + d for a zero result, where d = exponent difference.
  - N = 3 + d + k otherwise, where k = number of left-shift NORM cycles.
- busy is high from the cycle after the accept edge through the DONE cycle inclusive. It drops in the cycle after done.
- Back-to-back: start may be held high. The next accept occurs on the first IDLE cycle, i.e. the cycle after done.
- The maximum latency is bounded, so no timeout logic exists.

## Test plan
- Add, no alignment: a=8'h30, b=8'h30, op=0 → y=8'h40, ovf=unf=0, done at N=3.
- Add with alignment: a=8'h30, b=8'h10, op=0 → y=8'h34, done at N=5; busy high for cycles 1–5.
- Subtract, sign flip and normalization: a=8'h10, b=8'h30, op=1 → y=8'hA8, done at N=6.
- Flags:
  - a=8'h7F, b=8'h7F, op=0 → y=8'h7F, ovf=1.
  - a=8'h18, b=8'h10, op=1 → y=8'h00, unf=1, done at N=3.
- Zero cases:
  - a=8'h00, b=8'h35, op=1 → y=8'hB5, done at N=1.
  - a=b=8'h35, op=1 → y=8'h00, done at N=2.
- Control:
  - Pulse start again while busy → ignored, result unchanged.
  - Assert rst in the middle of ALIGN → next cycle IDLE, y=8'h00, busy=0, and no done pulse.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle sequencer for the 8-bit floating-point add/subtract.
// Format: [7] sign, [6:4] exponent e, [3:0] fraction f; value = 1.f * 2^e, e == 0 means zero.
// Phases: compare (on accept), one-bit-per-cycle alignment, add/subtract,
// one-bit-per-cycle normalization. All outputs come straight from registers.
module fp_addsub_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] y,
    output logic       ovf,
    output logic       unf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [2:0]  exp_r;      // working exponent of the result
    logic [2:0]  cnt_r;      // remaining alignment shifts
    logic [4:0]  ml_r;       // mantissa of the larger operand
    logic [4:0]  ms_r;       // mantissa of the smaller operand (shifted during ALIGN)
    logic [5:0]  sum_r;      // add/subtract result, normalized in NORM
    logic        sign_r;     // result sign
    logic        sub_r;      // effective subtraction
    logic [7:0]  y_r;
    logic        ovf_r;
    logic        unf_r;
    logic        busy_r;
    logic        done_r;

    // Operand decode used on the accept cycle.
    logic        sb_s;       // effective sign of B after applying op
    logic [2:0]  a_e_s;
    logic [2:0]  b_e_s;
    logic        a_ge_s;     // |A| >= |B|; ties keep A as the larger operand
    logic [2:0]  l_e_s;
    logic [2:0]  s_e_s;
    logic [4:0]  l_m_s;
    logic [4:0]  s_m_s;
    logic        l_sign_s;
    logic [2:0]  diff_s;
    logic        zero_op_s;
    logic [5:0]  sum_s;

    assign sb_s      = b[7] ^ op;
    assign a_e_s     = a[6:4];
    assign b_e_s     = b[6:4];
    assign a_ge_s    = (a[6:0] >= b[6:0]);
    assign l_e_s     = a_ge_s ? a_e_s : b_e_s;
    assign s_e_s     = a_ge_s ? b_e_s : a_e_s;
    assign l_m_s     = a_ge_s ? {1'b1, a[3:0]} : {1'b1, b[3:0]};
    assign s_m_s     = a_ge_s ? {1'b1, b[3:0]} : {1'b1, a[3:0]};
    assign l_sign_s  = a_ge_s ? a[7] : sb_s;
    assign diff_s    = l_e_s - s_e_s;
    assign zero_op_s = (a_e_s == 3'd0) || (b_e_s == 3'd0);

    // mL >= mS after alignment, so the subtraction never goes negative.
    assign sum_s = sub_r ? ({1'b0, ml_r} - {1'b0, ms_r})
                         : ({1'b0, ml_r} + {1'b0, ms_r});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (zero_op_s) begin
                        next_state_s = S_DONE;
                    end else if (diff_s != 3'd0) begin
                        next_state_s = S_ALIGN;
                    end else begin
                        next_state_s = S_ADD;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ALIGN: begin
                // The shift taken this cycle brings the counter to zero.
                if (cnt_r == 3'd1) begin
                    next_state_s = S_ADD;
                end else begin
                    next_state_s = S_ALIGN;
                end
            end
            S_ADD: begin
                if (sum_s == 6'd0) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_NORM;
                end
            end
            S_NORM: begin
                if (sum_r[5] || sum_r[4]) begin
                    next_state_s = S_DONE;
                end else if (exp_r == 3'd1) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_NORM;
                end
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != S_IDLE);
            done_r <= (next_state_s == S_DONE);
        end
    end

    // Datapath: capture, align, add/subtract, normalize; y is written on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_r  <= 3'd0;
            cnt_r  <= 3'd0;
            ml_r   <= 5'd0;
            ms_r   <= 5'd0;
            sum_r  <= 6'd0;
            sign_r <= 1'b0;
            sub_r  <= 1'b0;
            y_r    <= 8'h00;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                        if (a_e_s == 3'd0) begin
                            y_r <= {sb_s, b[6:0]};
                        end else if (b_e_s == 3'd0) begin
                            y_r <= a;
                        end else begin
                            exp_r  <= l_e_s;
                            cnt_r  <= diff_s;
                            ml_r   <= l_m_s;
                            ms_r   <= s_m_s;
                            sign_r <= l_sign_s;
                            sub_r  <= a[7] ^ sb_s;
                        end
                    end
                end
                S_ALIGN: begin
                    ms_r  <= ms_r >> 1;
                    cnt_r <= cnt_r - 3'd1;
                end
                S_ADD: begin
                    sum_r <= sum_s;
                    if (sum_s == 6'd0) begin
                        y_r <= 8'h00;
                    end
                end
                S_NORM: begin
                    if (sum_r[5]) begin
                        if (exp_r == 3'd7) begin
                            ovf_r <= 1'b1;
                            y_r   <= {sign_r, 7'h7F};
                        end else begin
                            sum_r <= sum_r >> 1;
                            exp_r <= exp_r + 3'd1;
                            y_r   <= {sign_r, exp_r + 3'd1, sum_r[4:1]};
                        end
                    end else if (sum_r[4]) begin
                        y_r <= {sign_r, exp_r, sum_r[3:0]};
                    end else if (exp_r == 3'd1) begin
                        unf_r <= 1'b1;
                        y_r   <= 8'h00;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 3'd1;
                    end
                end
                S_DONE: begin
                    y_r <= y_r;
                end
                default: begin
                    y_r <= y_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign y    = y_r;
    assign ovf  = ovf_r;
    assign unf  = unf_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed testbench for fp_addsub_seq; expected values are hand-computed.
// Latency N counts from the accept edge: done sampled just after that edge is N = 1.
module tb_fp_addsub_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] y;
    logic       ovf;
    logic       unf;

    int tests_run;
    int tests_failed;

    fp_addsub_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic top,
                         output int lat, output logic [7:0] ry, output logic rovf,
                         output logic runf, output logic busy_ok);
        @(posedge clk);
        @(negedge clk);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        ry = y; rovf = ovf; runf = unf;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; start = 1'b0; op = 1'b0; a = 8'h00; b = 8'h00;
        @(posedge clk); @(posedge clk);
        #1;
        tests_run++; if (y !== 8'h00)  begin tests_failed++; $display("FAIL reset_y got=%h exp=00", y); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++; if (ovf !== 1'b0)  begin tests_failed++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        tests_run++; if (unf !== 1'b0)  begin tests_failed++; $display("FAIL reset_unf got=%b exp=0", unf); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_noalign;
        int lat; logic [7:0] ry; logic rovf, runf, bok;
        do_op(8'h30, 8'h30, 1'b0, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'h40) begin tests_failed++; $display("FAIL add_noalign_y got=%h exp=40", ry); end
        tests_run++; if (lat != 3)     begin tests_failed++; $display("FAIL add_noalign_lat got=%0d exp=3", lat); end
        tests_run++; if (rovf !== 1'b0 || runf !== 1'b0) begin tests_failed++; $display("FAIL add_noalign_flags got=%b%b exp=00", rovf, runf); end
    endtask

    task automatic test_add_align;
        int lat; logic [7:0] ry; logic rovf, runf, bok;
        do_op(8'h30, 8'h10, 1'b0, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'h34) begin tests_failed++; $display("FAIL add_align_y got=%h exp=34", ry); end
        tests_run++; if (lat != 5)     begin tests_failed++; $display("FAIL add_align_lat got=%0d exp=5", lat); end
        tests_run++; if (bok !== 1'b1) begin tests_failed++; $display("FAIL add_align_busy got=%b exp=1", bok); end
        @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL add_align_after got busy=%b done=%b exp=0 0", busy, done); end
    endtask

    task automatic test_sub_norm;
        int lat; logic [7:0] ry; logic rovf, runf, bok;
        do_op(8'h10, 8'h30, 1'b1, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'hA8) begin tests_failed++; $display("FAIL sub_norm_y got=%h exp=A8", ry); end
        tests_run++; if (lat != 6)     begin tests_failed++; $display("FAIL sub_norm_lat got=%0d exp=6", lat); end
        // -8 + 2 = -6 (mixed signs through op=0)
        do_op(8'hB0, 8'h10, 1'b0, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'hA8) begin tests_failed++; $display("FAIL mixed_sign_y got=%h exp=A8", ry); end
        tests_run++; if (lat != 6)     begin tests_failed++; $display("FAIL mixed_sign_lat got=%0d exp=6", lat); end
    endtask

    task automatic test_flags;
        int lat; logic [7:0] ry; logic rovf, runf, bok;
        do_op(8'h7F, 8'h7F, 1'b0, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'h7F) begin tests_failed++; $display("FAIL ovf_y got=%h exp=7F", ry); end
        tests_run++; if (rovf !== 1'b1 || runf !== 1'b0) begin tests_failed++; $display("FAIL ovf_flags got=%b%b exp=10", rovf, runf); end
        do_op(8'h18, 8'h10, 1'b1, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'h00) begin tests_failed++; $display("FAIL unf_y got=%h exp=00", ry); end
        tests_run++; if (rovf !== 1'b0 || runf !== 1'b1) begin tests_failed++; $display("FAIL unf_flags got=%b%b exp=01", rovf, runf); end
        tests_run++; if (lat != 3)     begin tests_failed++; $display("FAIL unf_lat got=%0d exp=3", lat); end
    endtask

    task automatic test_zero;
        int lat; logic [7:0] ry; logic rovf, runf, bok;
        do_op(8'h00, 8'h35, 1'b1, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'hB5) begin tests_failed++; $display("FAIL zero_a_y got=%h exp=B5", ry); end
        tests_run++; if (lat != 1)     begin tests_failed++; $display("FAIL zero_a_lat got=%0d exp=1", lat); end
        do_op(8'h35, 8'h00, 1'b1, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'h35) begin tests_failed++; $display("FAIL zero_b_y got=%h exp=35", ry); end
        tests_run++; if (lat != 1)     begin tests_failed++; $display("FAIL zero_b_lat got=%0d exp=1", lat); end
        do_op(8'h35, 8'h35, 1'b1, lat, ry, rovf, runf, bok);
        tests_run++; if (ry !== 8'h00) begin tests_failed++; $display("FAIL zero_res_y got=%h exp=00", ry); end
        tests_run++; if (lat != 2)     begin tests_failed++; $display("FAIL zero_res_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_start_while_busy;
        int lat;
        logic idle_ok;
        @(posedge clk);
        @(negedge clk);
        a = 8'h30; b = 8'h10; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        a = 8'h7F; b = 8'h7F; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++; if (y !== 8'h34 || ovf !== 1'b0) begin tests_failed++; $display("FAIL busy_start_y got=%h ovf=%b exp=34 0", y, ovf); end
        tests_run++; if (lat != 5) begin tests_failed++; $display("FAIL busy_start_lat got=%0d exp=5", lat); end
        idle_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
        end
        tests_run++; if (idle_ok !== 1'b1) begin tests_failed++; $display("FAIL busy_start_idle got=%b exp=1", idle_ok); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] pattern;
        @(posedge clk);
        @(negedge clk);
        a = 8'h00; b = 8'h35; op = 1'b1; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            pattern[4 - i] = done;
        end
        start = 1'b0;
        tests_run++; if (pattern !== 5'b10101) begin tests_failed++; $display("FAIL b2b_done got=%b exp=10101", pattern); end
        tests_run++; if (y !== 8'hB5) begin tests_failed++; $display("FAIL b2b_y got=%h exp=B5", y); end
        @(posedge clk); @(posedge clk);
    endtask

    task automatic test_reset_mid_align;
        logic no_done;
        @(posedge clk);
        @(negedge clk);
        a = 8'h30; b = 8'h10; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        tests_run++; if (y !== 8'h00)   begin tests_failed++; $display("FAIL rst_mid_y got=%h exp=00", y); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        @(negedge clk);
        rst = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        tests_run++; if (no_done !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_discard got=%b exp=1", no_done); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = 8'h00; b = 8'h00;
        test_reset();
        test_add_noalign();
        test_add_align();
        test_sub_norm();
        test_flags();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_align();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
